// File: rtl/mux_lfmr_pkg.sv
// Elaboration-time helpers for the pipelined N:1 mux tree: unit width, tree depth and
// integer powers used to size each level.
package mux_lfmr_pkg;

  function automatic int unsigned ipow(input int unsigned base, input int unsigned e);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < e; i++) r = r * base;
    return r;
  endfunction

  // Smallest power-of-two unit width >= 2 whose LATENCY-level tree covers n lanes
  function automatic int unsigned calc_mux_size(input int unsigned n, input int unsigned lat);
    int unsigned m;
    m = 2;
    if (lat == 0) begin
      while (m < n) m = m * 2;
    end else begin
      while (ipow(m, lat) < n) m = m * 2;
    end
    return m;
  endfunction

  function automatic int unsigned calc_depth(input int unsigned n, input int unsigned m);
    int unsigned d;
    int unsigned p;
    d = 0;
    p = 1;
    while (p < n) begin
      p = p * m;
      d = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/mux_lfmr_unit.sv
// MUX_SIZE:1 lane selector with an optional output register; one per tree node.
module mux_unit
  import mux_lfmr_pkg::*;
#(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned MUX_SIZE = 2,
  parameter bit          REG      = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ce,
  input  logic [$clog2(MUX_SIZE)-1:0] sel,
  input  logic [MUX_SIZE*WIDTH-1:0]   in,
  output logic [WIDTH-1:0]            out
);

  localparam int unsigned SEL_WIDTH = $clog2(MUX_SIZE);

  logic [WIDTH-1:0] pick;

  always_comb begin
    pick = '0;
    for (int unsigned i = 0; i < MUX_SIZE; i++) begin
      if (sel == SEL_WIDTH'(i)) pick = in[i*WIDTH +: WIDTH];
    end
  end

  if (REG) begin : g_reg
    always_ff @(posedge clk) begin
      if (rst) out <= '0;
      else if (ce) out <= pick;
    end
  end else begin : g_comb
    // Purely combinational node: the clocking inputs are intentionally ignored
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst, ce};
    assign out = pick;
  end

endmodule

// File: rtl/mux_lfmr.sv
// Fixed-latency pipelined N:1 multiplexer built from a registered tree of MUX_SIZE:1
// units, with valid/error carried in a side pipeline aligned to the data.
module mux_lfmr
  import mux_lfmr_pkg::*;
#(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned INPUT_COUNT = 2,
  parameter int unsigned LATENCY     = 0,
  parameter int unsigned PRINT       = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ce,
  input  logic                           in_valid,
  input  logic [$clog2(INPUT_COUNT):0]   sel,
  input  logic [WIDTH*INPUT_COUNT-1:0]   in,
  output logic [WIDTH-1:0]               out,
  output logic                           out_valid,
  output logic                           out_err
);

  localparam int unsigned MUX_SIZE  = calc_mux_size(INPUT_COUNT, LATENCY);
  localparam int unsigned SEL_WIDTH = $clog2(MUX_SIZE);
  localparam int unsigned DEPTH     = calc_depth(INPUT_COUNT, MUX_SIZE);
  localparam int unsigned LEAVES    = ipow(MUX_SIZE, DEPTH);
  localparam int unsigned SELX      = DEPTH * SEL_WIDTH;
  localparam int unsigned BAL       = (LATENCY > DEPTH) ? LATENCY - DEPTH : 0;
  localparam bit          REG       = (LATENCY > 0);

  if (PRINT != 0) begin : g_print
    $info("mux_lfmr: MUX_SIZE=%0d DEPTH=%0d SEL_WIDTH=%0d balance=%0d leaves=%0d",
          MUX_SIZE, DEPTH, SEL_WIDTH, BAL, LEAVES);
  end

  logic [SELX-1:0]         sel_x;
  logic [LEAVES*WIDTH-1:0] leaves;
  logic                    err_in;
  logic                    err_root;
  logic [WIDTH-1:0]        root;

  // Lanes past INPUT_COUNT read as zero; upper sel bits only matter for the error flag
  assign sel_x  = SELX'(sel);
  assign leaves = (LEAVES*WIDTH)'(in);
  assign err_in = 32'(sel) >= INPUT_COUNT;

  if (LATENCY == 0) begin : g_side
    assign out_valid = in_valid;
    assign out_err   = err_in;
    assign err_root  = err_in;
  end else begin : g_side
    logic [LATENCY-1:0] valid_q;
    logic [LATENCY-1:0] err_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= '0;
        err_q   <= '0;
      end else if (ce) begin
        valid_q[0] <= in_valid;
        err_q[0]   <= err_in;
        for (int unsigned s = 1; s < LATENCY; s++) begin
          valid_q[s] <= valid_q[s-1];
          err_q[s]   <= err_q[s-1];
        end
      end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_err   = err_q[LATENCY-1];

    // Error flag that travels alongside the data entering the root level
    if (DEPTH == 1) begin : g_eroot
      assign err_root = err_in;
    end else begin : g_eroot
      assign err_root = err_q[DEPTH-2];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_lvl
    localparam int unsigned NK = ipow(MUX_SIZE, DEPTH - k);
    localparam int unsigned NU = NK / MUX_SIZE;
    localparam int unsigned SK = (DEPTH - k) * SEL_WIDTH;

    logic [SK-1:0]       sel_l;
    logic [NK*WIDTH-1:0] din;
    logic [NK*WIDTH-1:0] din_m;
    logic [NU*WIDTH-1:0] dout;

    if (k == 0) begin : g_src
      assign sel_l = sel_x;
      assign din   = leaves;
    end else begin : g_src
      assign sel_l = g_lvl[k-1].g_nx.sel_nx;
      assign din   = g_lvl[k-1].dout;
    end

    // Zeroing the root input makes any out-of-range select produce out=0
    if (k == DEPTH - 1) begin : g_mask
      assign din_m = err_root ? '0 : din;
    end else begin : g_mask
      assign din_m = din;
    end

    if (k + 1 < DEPTH) begin : g_nx
      logic [SK-SEL_WIDTH-1:0] sel_nx;
      always_ff @(posedge clk) begin
        if (rst) sel_nx <= '0;
        else if (ce) sel_nx <= sel_l[SK-1:SEL_WIDTH];
      end
    end

    if (PRINT != 0) begin : g_print
      $info("mux_lfmr: level %0d uses %0d units on sel[%0d +: %0d]",
            k, NU, k * SEL_WIDTH, SEL_WIDTH);
    end

    for (genvar u = 0; u < NU; u++) begin : g_unit
      mux_unit #(
        .WIDTH   (WIDTH),
        .MUX_SIZE(MUX_SIZE),
        .REG     (REG)
      ) u_mux (
        .clk(clk),
        .rst(rst),
        .ce (ce),
        .sel(sel_l[SEL_WIDTH-1:0]),
        .in (din_m[u*MUX_SIZE*WIDTH +: MUX_SIZE*WIDTH]),
        .out(dout[u*WIDTH +: WIDTH])
      );
    end
  end

  assign root = g_lvl[DEPTH-1].dout;

  if (BAL == 0) begin : g_bal
    assign out = root;
  end else begin : g_bal
    logic [WIDTH-1:0] bal_q [BAL];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < BAL; i++) bal_q[i] <= '0;
      end else if (ce) begin
        bal_q[0] <= root;
        for (int unsigned i = 1; i < BAL; i++) bal_q[i] <= bal_q[i-1];
      end
    end

    assign out = bal_q[BAL-1];
  end

endmodule

// File: tb/tb_mux_lfmr.sv
// Scoreboard bench for mux_lfmr: two pipelined configurations under random traffic with
// ce stalls and a mid-stream reset, plus a combinational LATENCY=0 instance.
module tb_mux_lfmr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   phase = 0;

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       e;
    int         due;
  } exp_t;

  // Config 0: 8 lanes, latency 3 (binary tree, no balancing).
  // Config 1: 5 lanes, latency 4 (binary tree over 8 leaves plus one balancing stage).
  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int IC  = (g == 0) ? 8 : 5;
    localparam int LAT = (g == 0) ? 3 : 4;

    logic            in_valid = 1'b0;
    logic [3:0]      sel      = '0;
    logic [8*IC-1:0] lanes    = '0;
    logic [7:0]      out;
    logic            out_valid;
    logic            out_err;
    exp_t            q[$];
    int              adv      = 0;
    bit              last_adv = 1'b0;
    bit              last_rst = 1'b0;
    logic [7:0]      h_out    = '0;
    logic            h_valid  = 1'b0;
    logic            h_err    = 1'b0;

    mux_lfmr #(
      .WIDTH(8), .INPUT_COUNT(IC), .LATENCY(LAT), .PRINT(0)
    ) dut (
      .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .sel(sel), .in(lanes),
      .out(out), .out_valid(out_valid), .out_err(out_err)
    );

    // Count advancing edges; a reset edge discards everything in flight
    initial forever begin
      @(posedge clk);
      last_adv = ce && !rst;
      last_rst = rst;
      if (last_adv) adv++;
      if (rst) q.delete();
    end

    // Stimulus: expected result is computed from the lane table and queued with its due edge
    initial forever begin
      @(posedge clk);
      #2;
      if (phase == 1) begin
        for (int k = 0; k < IC; k++) lanes[k*8 +: 8] = 8'(16 * (g + 1) + k);
        sel      = 4'(cyc);
        in_valid = 1'b1;
      end else if (phase == 2) begin
        for (int k = 0; k < IC; k++) lanes[k*8 +: 8] = 8'($urandom);
        sel      = 4'($urandom);
        in_valid = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && ce && !rst) begin
        exp_t e;
        int   idx;
        idx   = int'(sel);
        e.e   = (idx >= IC);
        e.d   = e.e ? 8'h00 : lanes[idx*8 +: 8];
        e.due = adv + LAT;
        q.push_back(e);
      end
    end

    // Monitor
    initial forever begin
      exp_t e;
      bit   want_valid;
      @(negedge clk);
      if (last_rst) begin
        total++;
        if (out !== 8'h00 || out_valid !== 1'b0 || out_err !== 1'b0) begin
          bad++;
          $display("FAIL reset_cfg%0d got out=%h valid=%b err=%b want 00/0/0",
                   g, out, out_valid, out_err);
        end
      end else if (!last_adv) begin
        total++;
        if ({out, out_valid, out_err} !== {h_out, h_valid, h_err}) begin
          bad++;
          $display("FAIL hold_cfg%0d got out=%h valid=%b err=%b want out=%h valid=%b err=%b",
                   g, out, out_valid, out_err, h_out, h_valid, h_err);
        end
      end else begin
        want_valid = (q.size() != 0) && (q[0].due == adv);
        total++;
        if (out_valid !== want_valid) begin
          bad++;
          $display("FAIL valid_cfg%0d adv=%0d got=%b want=%b", g, adv, out_valid, want_valid);
          if (want_valid) void'(q.pop_front());
        end else if (want_valid) begin
          e = q.pop_front();
          total++;
          if (out !== e.d || out_err !== e.e) begin
            bad++;
            $display("FAIL data_cfg%0d adv=%0d got out=%h err=%b want out=%h err=%b",
                     g, adv, out, out_err, e.d, e.e);
          end
        end
      end
      h_out   = out;
      h_valid = out_valid;
      h_err   = out_err;
    end
  end

  // Combinational instance: 3 lanes, latency 0
  logic        c_valid = 1'b0;
  logic [2:0]  c_sel   = '0;
  logic [23:0] c_in    = '0;
  logic [7:0]  c_out;
  logic        c_ovalid;
  logic        c_err;

  mux_lfmr #(
    .WIDTH(8), .INPUT_COUNT(3), .LATENCY(0), .PRINT(0)
  ) dut_c (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(c_valid), .sel(c_sel), .in(c_in),
    .out(c_out), .out_valid(c_ovalid), .out_err(c_err)
  );

  initial begin
    for (int i = 0; i < 24; i++) begin
      logic [7:0] eo;
      logic       ee;
      int         idx;
      @(negedge clk);
      #2;
      c_in    = {8'($urandom), 8'($urandom), 8'($urandom)};
      c_sel   = (i < 8) ? 3'(i) : 3'($urandom);
      c_valid = 1'($urandom);
      #1;
      idx = int'(c_sel);
      ee  = (idx >= 3);
      eo  = ee ? 8'h00 : c_in[idx*8 +: 8];
      total++;
      if (c_out !== eo || c_err !== ee || c_ovalid !== c_valid) begin
        bad++;
        $display("FAIL comb sel=%0d got out=%h err=%b valid=%b want out=%h err=%b valid=%b",
                 c_sel, c_out, c_err, c_ovalid, eo, ee, c_valid);
      end
    end
  end

  task automatic step(input bit r, input bit c, input int ph, input int cy);
    @(posedge clk);
    #1;
    rst   = r;
    ce    = c;
    phase = ph;
    cyc   = cy;
  endtask

  // Control: reset, directed sweep, random traffic with a stall window and a mid-stream reset, drain
  initial begin
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 0, 0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1, i);
    for (int i = 0; i < 300; i++) begin
      bit r;
      bit c;
      r = (i == 150 || i == 151);
      c = (i >= 50 && i < 54) ? 1'b0 : ($urandom_range(0, 4) != 0);
      step(r, c, 2, i);
    end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 0, i);
    @(negedge clk);
    #1;
    total++;
    if (g_cfg[0].q.size() != 0) begin
      bad++;
      $display("FAIL drain_cfg0 got %0d outstanding want 0", g_cfg[0].q.size());
    end
    total++;
    if (g_cfg[1].q.size() != 0) begin
      bad++;
      $display("FAIL drain_cfg1 got %0d outstanding want 0", g_cfg[1].q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_lfmr.md
# mux_lfmr

Fixed-latency pipelined N:1 multiplexer: the gathering counterpart of the pipelined demultiplexer. It selects one of `INPUT_COUNT` `WIDTH`-bit lanes by `sel` and presents it on `out` exactly `LATENCY` clocks later, with a matching `out_valid`. The selection is done through a registered tree of power-of-two mux units sized from `LATENCY`. It sits at the join points of high-speed datapaths where several producers feed one consumer and timing closure needs registers inside the selection.

## Interface
- `WIDTH`, 1: lane width in bits.
- `INPUT_COUNT`, 2: number of input lanes, ≥2.
- `LATENCY`, 0: clocks from `in`/`sel`/`in_valid` to `out`/`out_valid`. 0 gives a purely combinational path.
- `PRINT`, 0: nonzero prints elaboration-time structure (`MUX_SIZE`, depth, unit map) via `$display`.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ce`  in  1  pipeline advance enable. 0 freezes every stage.
- `in_valid`  in  1  qualifies `in`/`sel` this cycle.
- `sel`  in  `$clog2(INPUT_COUNT)+1`  lane index.
- `in`  in  `WIDTH*INPUT_COUNT`  lane k at `in[k*WIDTH +: WIDTH]`.
- `out`  out  `WIDTH`  selected lane, delayed.
- `out_valid`  out  1  `in_valid` delayed identically.
- `out_err`  out  1  `sel >= INPUT_COUNT` for the sample on `out`.

## Operation
- `MUX_SIZE` is the smallest power of two ≥2 with `MUX_SIZE^LATENCY >= INPUT_COUNT`. When `LATENCY`=0 it is `2^$clog2(INPUT_COUNT)`.
- `SEL_WIDTH = $clog2(MUX_SIZE)`.
- `DEPTH = ceil(log_MUX_SIZE(INPUT_COUNT))` levels. Level 0 is the leaves.
- Level k uses `sel[k*SEL_WIDTH +: SEL_WIDTH]`.
- Leaf inputs with index ≥ `INPUT_COUNT` are tied to 0.
- Each level output is registered when `LATENCY`>0. The unused upper `sel` bits, `in_valid` and the error flag travel in a side pipeline aligned with the data.
- If `DEPTH < LATENCY`, `LATENCY-DEPTH` balancing registers follow the root, so total latency is always exactly `LATENCY`.
- Out-of-range `sel` (≥ `INPUT_COUNT`): `out`=0, `out_err`=1, `out_valid` still follows `in_valid`.
- `in_valid`=0 samples still propagate data. `out` is don't-care-but-deterministic (the selected lane), and `out_valid`=0.

## Timing
- `ce`=1: every stage advances each clock. A sample accepted at edge t appears at edge t+`LATENCY`.
- `ce`=0: all stages, including valid/err, hold. Outputs are unchanged. Latency counts only `ce`=1 edges.
- `rst`=1 at an edge clears all data, sel, valid and err registers to 0, overriding `ce`. Outputs read `out`=0, `out_valid`=0, `out_err`=0 from the next cycle.
- `rst` mid-stream discards every in-flight sample. The first valid sample after reset appears `LATENCY` advancing edges after acceptance.
- `LATENCY`=0: no registers. `rst`/`ce` have no effect, and outputs follow inputs combinationally.
- Back-to-back samples with different `sel` each cycle produce one result per cycle in order. There is no interaction between samples.

## Structure
- `MUX_SIZE`, `DEPTH` and unit-address math come from the shared N-ary recursion helper include (`recursion_iterators.vh`), as the demux uses. No new package is needed. If a helper for "smallest power-of-two width for latency" is missing, add it there.
- One sub-module: `mux_unit`. It is a `MUX_SIZE`:1 selector with an optional output register, `ce` and `rst`, and is instantiated per tree node under generate loops.
- `out_err` is computed once at input and piped in the side pipeline.

## Test plan
- `INPUT_COUNT`=8, `LATENCY`=3 (`MUX_SIZE`=2), lanes k=0x10+k, `sel`=5, `in_valid`=1 at edge 0 → `out`=0x15 and `out_valid`=1 exactly at edge 3, not before.
- Same config, `sel` stepping 0..7 on consecutive cycles → `out` 0x10..0x17 on edges 3..10, `out_valid` high throughout.
- `INPUT_COUNT`=4, `LATENCY`=3 (`DEPTH`=2, 1 balancing stage), `sel`=2 → result at edge 3. `INPUT_COUNT`=5, `sel`=6 → `out`=0, `out_err`=1.
- Drop `ce` for 4 cycles with 3 samples in flight → outputs frozen, then resume in order with no loss or duplication.
- Assert `rst` with the pipeline full → next cycle `out`=0 and `out_valid`=0. New sample after deassert → appears after `LATENCY`.
- `LATENCY`=0, `INPUT_COUNT`=3 → `out` tracks `in`/`sel` in the same cycle. `sel`=3 → `out_err`=1, `out`=0.
